// File: rtl/pio_pkg.sv
// -----------------------------------------------------------------------------
// pio_pkg
// Shared constants, FSM state type and the count-field decoder for the PIO
// output shift register (OSR) stage.
//
// Contents:
//   DATA_W        OSR / TX FIFO word width (fixed at 32)
//   CNT_W         width of shift-count and bit-count fields (holds 0..32)
//   osr_state_t   IDLE, OUT_STALL, PULL_STALL
//   decode_count  maps the 6-bit count encoding to a bit count (0 -> 32)
// -----------------------------------------------------------------------------
package pio_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OUT_STALL  = 2'd1,
        PULL_STALL = 2'd2
    } osr_state_t;

    // A field value of zero means a full word; every other value is literal.
    function automatic logic [CNT_W-1:0] decode_count(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(DATA_W) : v;
    endfunction

endpackage

// File: rtl/pio_shift_extract.sv
// -----------------------------------------------------------------------------
// pio_shift_extract
// Purely combinational shifter for the OSR. Pulls n bits out of the OSR in
// the selected direction and returns the right-aligned extracted bits together
// with the OSR value left behind (vacated positions are zero-filled).
//
// Ports:
//   osr          in   32  current OSR contents
//   n            in   6   number of bits to extract, 1..32 (already decoded)
//   shift_right  in   1   1 = take LSBs first, 0 = take MSBs first
//   bits         out  32  extracted bits, right-aligned
//   osr_next     out  32  OSR after the shift
// -----------------------------------------------------------------------------
module pio_shift_extract
    import pio_pkg::*;
(
    input  logic [DATA_W-1:0] osr,
    input  logic [CNT_W-1:0]  n,
    input  logic              shift_right,
    output logic [DATA_W-1:0] bits,
    output logic [DATA_W-1:0] osr_next
);

    logic [DATA_W-1:0] low_mask;
    logic [CNT_W-1:0]  n_comp;

    // Shift amounts equal to the word width produce zero, so n = 32 needs no
    // special case: the mask becomes all ones and the remainder becomes zero.
    always_comb begin
        low_mask = ~({DATA_W{1'b1}} << n);
        n_comp   = CNT_W'(DATA_W) - n;
        if (shift_right) begin
            bits     = osr & low_mask;
            osr_next = osr >> n;
        end else begin
            bits     = osr >> n_comp;
            osr_next = osr << n;
        end
    end

endmodule

// File: rtl/pio_osr.sv
// -----------------------------------------------------------------------------
// pio_osr
// Output shift register stage of the PIO state machine, directly upstream of
// the pin driver. Takes 32-bit words from the TX FIFO and emits 1..32 bits per
// OUT request on write_data / write_enable. Supports explicit PULL (blocking
// and non-blocking) and threshold-based autopull.
//
// Optional feature: define PIO_OSR_STALL_STATS_EN to add a saturating 16-bit
// stall cycle counter (stall_cycles) with a synchronous clear (stats_clear).
//
// Ports:
//   clock           in   1   system clock
//   reset_n         in   1   synchronous reset, active-low
//   cfg_shiftRight  in   1   1 = shift right (LSB first), 0 = shift left
//   cfg_autoPull    in   1   enable autopull
//   cfg_pullThresh  in   6   autopull threshold in bits (0 = 32)
//   tx_data         in   32  TX FIFO head word
//   tx_valid        in   1   TX FIFO not empty
//   tx_ready        out  1   pop strobe to TX FIFO
//   out_req         in   1   OUT request, held until out_done
//   out_count       in   6   bits to shift out (0 = 32)
//   out_done        out  1   one-cycle OUT completion pulse
//   pull_req        in   1   explicit PULL, held until pull_done
//   pull_block      in   1   1 = blocking PULL
//   x_in            in   32  X value loaded by non-blocking PULL on empty FIFO
//   pull_done       out  1   one-cycle PULL completion pulse
//   stall           out  1   high while a request waits on an empty FIFO
//   write_data      out  32  bits for the pin block, right-aligned
//   write_enable    out  1   one-cycle strobe qualifying write_data
//   osr_count       out  6   shift count (0 = full, 32 = empty)
//   stats_clear     in   1   (optional) zero the stall counter
//   stall_cycles    out  16  (optional) saturating stall cycle count
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | accepting PULL / OUT, background autopull, executing OUTs
// OUT_STALL  | OUT needs a refill but the FIFO is empty; waiting tx_valid
// PULL_STALL | blocking PULL on an empty FIFO; waiting tx_valid
// -----------------------------------------------------------------------------
module pio_osr
    import pio_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_shiftRight,
    input  logic              cfg_autoPull,
    input  logic [CNT_W-1:0]  cfg_pullThresh,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              out_req,
    input  logic [CNT_W-1:0]  out_count,
    output logic              out_done,
    input  logic              pull_req,
    input  logic              pull_block,
    input  logic [DATA_W-1:0] x_in,
    output logic              pull_done,
    output logic              stall,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    output logic [CNT_W-1:0]  osr_count
`ifdef PIO_OSR_STALL_STATS_EN
    ,
    input  logic              stats_clear,
    output logic [15:0]       stall_cycles
`endif
);

    osr_state_t        state;
    osr_state_t        state_d;
    logic [DATA_W-1:0] osr;
    logic [DATA_W-1:0] osr_d;
    logic [DATA_W-1:0] wd_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              we_d;
    logic              od_d;
    logic              pd_d;
    logic              pop;

    logic [CNT_W-1:0]  n_bits;
    logic [CNT_W-1:0]  th_bits;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_sat;
    logic              refill;
    logic              out_live;
    logic              pull_live;
    logic [DATA_W-1:0] ext_bits;
    logic [DATA_W-1:0] ext_next;

    assign n_bits  = decode_count(out_count);
    assign th_bits = decode_count(cfg_pullThresh);
    assign refill  = cfg_autoPull && (osr_count >= th_bits);

    // A requester holds its request until it sees the done pulse, so the
    // request is ignored during that pulse to avoid servicing it twice.
    assign out_live  = out_req && !out_done;
    assign pull_live = pull_req && !pull_done;

    assign cnt_sum = {1'b0, osr_count} + {1'b0, n_bits};
    assign cnt_sat = (cnt_sum > (CNT_W+1)'(DATA_W)) ? CNT_W'(DATA_W) : cnt_sum[CNT_W-1:0];

    pio_shift_extract u_shift_extract (
        .osr         (osr),
        .n           (n_bits),
        .shift_right (cfg_shiftRight),
        .bits        (ext_bits),
        .osr_next    (ext_next)
    );

    always_comb begin
        state_d = state;
        osr_d   = osr;
        cnt_d   = osr_count;
        wd_d    = write_data;
        we_d    = 1'b0;
        od_d    = 1'b0;
        pd_d    = 1'b0;
        pop     = 1'b0;

        case (state)
            IDLE: begin
                if (pull_live) begin
                    if (tx_valid) begin
                        pop  = 1'b1;
                        pd_d = 1'b1;
                    end else if (!pull_block) begin
                        osr_d = x_in;
                        cnt_d = '0;
                        pd_d  = 1'b1;
                    end else begin
                        state_d = PULL_STALL;
                    end
                end else if (out_live && refill) begin
                    // Refill first; the OUT itself runs on the following cycle.
                    if (tx_valid) begin
                        pop = 1'b1;
                    end else begin
                        state_d = OUT_STALL;
                    end
                end else if (out_live) begin
                    osr_d = ext_next;
                    wd_d  = ext_bits;
                    cnt_d = cnt_sat;
                    we_d  = 1'b1;
                    od_d  = 1'b1;
                end else if (refill && tx_valid) begin
                    pop = 1'b1;
                end
            end
            OUT_STALL: begin
                if (tx_valid) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            PULL_STALL: begin
                if (tx_valid) begin
                    pop     = 1'b1;
                    pd_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            osr_d = tx_data;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            osr          <= '0;
            osr_count    <= CNT_W'(DATA_W);
            write_data   <= '0;
            write_enable <= 1'b0;
            out_done     <= 1'b0;
            pull_done    <= 1'b0;
        end else begin
            state        <= state_d;
            osr          <= osr_d;
            osr_count    <= cnt_d;
            write_data   <= wd_d;
            write_enable <= we_d;
            out_done     <= od_d;
            pull_done    <= pd_d;
        end
    end

    // Gated by reset_n so nothing is popped or flagged in a cycle whose edge
    // will discard the load anyway.
    assign tx_ready = reset_n && pop;
    assign stall    = reset_n && (state != IDLE);

`ifdef PIO_OSR_STALL_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset_n || stats_clear) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pio_osr.sv
// -----------------------------------------------------------------------------
// tb_pio_osr
// Self-checking bench for pio_osr with a transaction-level reference model,
// directed scenarios, a randomized phase and a standalone check of
// pio_shift_extract.
// -----------------------------------------------------------------------------
module tb_pio_osr;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cfg_shiftRight;
    logic        cfg_autoPull;
    logic [5:0]  cfg_pullThresh;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        out_req;
    logic [5:0]  out_count;
    logic        out_done;
    logic        pull_req;
    logic        pull_block;
    logic [31:0] x_in;
    logic        pull_done;
    logic        stall;
    logic [31:0] write_data;
    logic        write_enable;
    logic [5:0]  osr_count;
`ifdef PIO_OSR_STALL_STATS_EN
    logic        stats_clear;
    logic [15:0] stall_cycles;
`endif

    logic [31:0] se_osr;
    logic [5:0]  se_n;
    logic        se_dir;
    logic [31:0] se_bits;
    logic [31:0] se_next;

    always #5 clock = ~clock;

    pio_osr dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cfg_shiftRight (cfg_shiftRight),
        .cfg_autoPull   (cfg_autoPull),
        .cfg_pullThresh (cfg_pullThresh),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .out_req        (out_req),
        .out_count      (out_count),
        .out_done       (out_done),
        .pull_req       (pull_req),
        .pull_block     (pull_block),
        .x_in           (x_in),
        .pull_done      (pull_done),
        .stall          (stall),
        .write_data     (write_data),
        .write_enable   (write_enable),
        .osr_count      (osr_count)
`ifdef PIO_OSR_STALL_STATS_EN
        ,
        .stats_clear    (stats_clear),
        .stall_cycles   (stall_cycles)
`endif
    );

    pio_shift_extract u_se (
        .osr         (se_osr),
        .n           (se_n),
        .shift_right (se_dir),
        .bits        (se_bits),
        .osr_next    (se_next)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    // Reference model: OSR word, bit count, pending-request flags, outputs.
    logic [31:0] m_osr;
    logic [31:0] m_wd;
    int          m_cnt;
    bit          m_we, m_od, m_pd;
    bit          m_wait_out, m_wait_pull;

    // DUT samples from the most recent tick.
    logic        s_tx_ready, s_stall, s_we, s_od, s_pd;
    logic [31:0] s_wd;
    logic [5:0]  s_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Word-level arithmetic view of taking n bits from a 32-bit register.
    task automatic extract(input logic [31:0] v, input int n, input bit right,
                           output logic [31:0] bits, output logic [31:0] rest);
        longint unsigned w;
        w = 64'(v);
        if (right) begin
            bits = 32'(w % (64'd1 << n));
            rest = 32'(w >> n);
        end else begin
            bits = 32'(w >> (32 - n));
            rest = 32'(w << n);
        end
    endtask

    task automatic model_reset();
        m_osr = 0; m_cnt = 32; m_wd = 0;
        m_we = 0; m_od = 0; m_pd = 0;
        m_wait_out = 0; m_wait_pull = 0;
    endtask

    task automatic model_step(output bit e_pop, output bit e_stall);
        int th, n;
        logic [31:0] b, r;
        bit need, pull_live, out_live;
        e_pop = 0;
        e_stall = 0;
        if (!reset_n) begin
            model_reset();
        end else begin
            th = (cfg_pullThresh == 0) ? 32 : int'(cfg_pullThresh);
            n  = (out_count == 0) ? 32 : int'(out_count);
            e_stall   = m_wait_out || m_wait_pull;
            need      = cfg_autoPull && (m_cnt >= th);
            pull_live = pull_req && !m_pd;
            out_live  = out_req && !m_od;
            m_we = 0; m_od = 0; m_pd = 0;
            if (m_wait_pull) begin
                if (tx_valid) begin e_pop = 1; m_wait_pull = 0; m_pd = 1; end
            end else if (m_wait_out) begin
                if (tx_valid) begin e_pop = 1; m_wait_out = 0; end
            end else if (pull_live) begin
                if (tx_valid) begin
                    e_pop = 1; m_pd = 1;
                end else if (!pull_block) begin
                    m_osr = x_in; m_cnt = 0; m_pd = 1;
                end else begin
                    m_wait_pull = 1;
                end
            end else if (out_live && need) begin
                if (tx_valid) e_pop = 1;
                else m_wait_out = 1;
            end else if (out_live) begin
                extract(m_osr, n, cfg_shiftRight, b, r);
                m_wd  = b;
                m_osr = r;
                m_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
                m_we  = 1; m_od = 1;
            end else if (need && tx_valid) begin
                e_pop = 1;
            end
            if (e_pop) begin
                m_osr = tx_data;
                m_cnt = 0;
            end
        end
    endtask

    // Called just after a negedge with this cycle's inputs driven; compares
    // every output against the model, advances the model, waits a cycle.
    task automatic tick();
        bit e_pop, e_stall, ewe, eod, epd;
        logic [31:0] ewd;
        int ecnt;
        #1;
        ewd = m_wd; ewe = m_we; eod = m_od; epd = m_pd; ecnt = m_cnt;
        model_step(e_pop, e_stall);
        s_tx_ready = tx_ready; s_stall = stall; s_we = write_enable;
        s_od = out_done; s_pd = pull_done; s_wd = write_data; s_cnt = osr_count;
        chk("tx_ready", 32'(tx_ready), 32'(e_pop));
        chk("stall", 32'(stall), 32'(e_stall));
        chk("write_enable", 32'(write_enable), 32'(ewe));
        chk("out_done", 32'(out_done), 32'(eod));
        chk("pull_done", 32'(pull_done), 32'(epd));
        chk("write_data", write_data, ewd);
        chk("osr_count", 32'(osr_count), 32'(ecnt));
        if (tx_ready === 1'b1) pops++;
        @(negedge clock);
    endtask

    task automatic do_pull(input bit blk);
        pull_block = blk;
        pull_req = 1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (m_pd) break;
        end
        pull_req = 0;
        chk("pull_done_seen", 32'(m_pd), 1);
        tick();
    endtask

    task automatic do_out(input int n, input logic [31:0] exp_wd, input int exp_cnt);
        out_count = 6'(n);
        out_req = 1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (m_od) break;
        end
        out_req = 0;
        chk("out_done_seen", 32'(m_od), 1);
        tick();
        chk("out_lit_wd", s_wd, exp_wd);
        chk("out_lit_cnt", 32'(s_cnt), exp_cnt);
    endtask

    initial begin
        int st;
        logic [31:0] eb, er;
        reset_n = 0; cfg_shiftRight = 0; cfg_autoPull = 0; cfg_pullThresh = 0;
        tx_data = 0; tx_valid = 0; out_req = 0; out_count = 0;
        pull_req = 0; pull_block = 0; x_in = 0;
`ifdef PIO_OSR_STALL_STATS_EN
        stats_clear = 0;
`endif
        model_reset();

        // Standalone shifter: literal cases, then random against arithmetic.
        se_osr = 32'h80000001; se_n = 6'd1; se_dir = 0; #1;
        chk("se_lit_bits", se_bits, 32'h1);
        chk("se_lit_next", se_next, 32'h2);
        se_osr = 32'hDEADBEEF; se_n = 6'd32; se_dir = 1; #1;
        chk("se_lit32_bits", se_bits, 32'hDEADBEEF);
        chk("se_lit32_next", se_next, 32'h0);
        for (int i = 0; i < 40; i++) begin
            se_osr = $urandom;
            se_n = 6'($urandom_range(1, 32));
            se_dir = 1'($urandom_range(0, 1));
            #1;
            extract(se_osr, int'(se_n), se_dir, eb, er);
            chk("se_bits", se_bits, eb);
            chk("se_next", se_next, er);
        end

        @(negedge clock);
        tick();
        tick();
        chk("rst_cnt", 32'(s_cnt), 32);
        chk("rst_we", 32'(s_we), 0);
        chk("rst_wd", s_wd, 0);
        reset_n = 1;

        // PULL then four byte OUTs, shift right.
        cfg_shiftRight = 1;
        tx_data = 32'hDEADBEEF; tx_valid = 1; pops = 0;
        do_pull(0);
        tx_valid = 0;
        chk("pull_pops", pops, 1);
        chk("pull_cnt", 32'(s_cnt), 0);
        do_out(8, 32'hEF, 8);
        do_out(8, 32'hBE, 16);
        do_out(8, 32'hAD, 24);
        do_out(8, 32'hDE, 32);

        // Shift left, one bit then a full word.
        cfg_shiftRight = 0;
        tx_data = 32'h80000001; tx_valid = 1;
        do_pull(0);
        tx_valid = 0;
        do_out(1, 32'h1, 1);
        do_out(0, 32'h2, 32);

        // Autopull with threshold 16 on an empty FIFO.
        cfg_shiftRight = 1;
        tx_data = 32'hDEADBEEF; tx_valid = 1;
        do_pull(0);
        tx_valid = 0;
        cfg_autoPull = 1; cfg_pullThresh = 6'd16;
        do_out(16, 32'hBEEF, 16);
        out_count = 6'd16; out_req = 1; st = 0;
        repeat (6) begin tick(); st += int'(s_stall); end
        chk("ap_stall_cycles", st, 5);
        pops = 0;
        tx_data = 32'hCAFE1234; tx_valid = 1;
        tick();
        tx_valid = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (m_od) break;
        end
        out_req = 0;
        tick();
        chk("ap_wd", s_wd, 32'h1234);
        chk("ap_pops", pops, 1);
        chk("ap_cnt", 32'(s_cnt), 16);
        cfg_autoPull = 0;

        // Non-blocking PULL from X, then blocking PULL.
        tx_valid = 0; x_in = 32'h12345678; pops = 0;
        do_pull(0);
        chk("nb_pops", pops, 0);
        do_out(0, 32'h12345678, 32);
        pull_block = 1; pull_req = 1;
        repeat (4) tick();
        chk("blk_stall", 32'(s_stall), 1);
        pops = 0;
        tx_data = 32'hA5A55A5A; tx_valid = 1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (m_pd) break;
        end
        pull_req = 0; tx_valid = 0;
        tick();
        chk("blk_pops", pops, 1);
        do_out(0, 32'hA5A55A5A, 32);

        // Reset while PULL_STALL.
        pull_block = 1; pull_req = 1; tx_valid = 0;
        repeat (3) tick();
        chk("rs_stall_before", 32'(s_stall), 1);
        reset_n = 0; pull_req = 0;
        tick();
        reset_n = 1;
        tick();
        chk("rs_stall", 32'(s_stall), 0);
        chk("rs_cnt", 32'(s_cnt), 32);
        chk("rs_pd", 32'(s_pd), 0);
        chk("rs_wd", s_wd, 0);
        pops = 0;
        tx_data = 32'h0BADF00D; tx_valid = 1;
        repeat (4) tick();
        chk("rs_pops", pops, 0);
        tx_valid = 0;

        // Randomized phase.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 0; out_req = 0; pull_req = 0;
            end else begin
                reset_n = 1;
                if (m_od) out_req = 0;
                if (m_pd) pull_req = 0;
                if (!out_req && !pull_req && !m_wait_out && !m_wait_pull) begin
                    if ($urandom_range(0, 7) == 0) begin
                        cfg_shiftRight = 1'($urandom_range(0, 1));
                        cfg_autoPull   = 1'($urandom_range(0, 1));
                        cfg_pullThresh = 6'($urandom_range(0, 32));
                    end
                    if ($urandom_range(0, 2) == 0) begin
                        out_count  = 6'($urandom_range(0, 32));
                        pull_block = 1'($urandom_range(0, 1));
                        case ($urandom_range(0, 3))
                            0:       pull_req = 1;
                            1, 2:    out_req = 1;
                            default: begin pull_req = 1; out_req = 1; end
                        endcase
                    end
                end
            end
            tx_valid = ($urandom_range(0, 2) != 0);
            tx_data  = $urandom;
            x_in     = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_osr.md
Name: pio_osr

Overview:
- Output shift register stage of the PIO state machine. It sits directly upstream of the pin driver.
- It takes 32-bit words from the TX FIFO. It emits 1–32 bits per OUT request as `write_data`/`write_enable` into the pin block.
- Supports explicit PULL (blocking and non-blocking) and threshold-based autopull.

Parameters:
- DATA_W, 32, OSR and FIFO word width; fixed at 32, other values unsupported.
- CNT_W, 6, width of shift count and bit-count fields (holds 0..32).

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous reset, active-low
- cfg_shiftRight  input  1  1 = shift right (LSB first); 0 = shift left (MSB first)
- cfg_autoPull  input  1  enable autopull
- cfg_pullThresh  input  6  autopull threshold in bits; 0 encodes 32
- tx_data  input  32  TX FIFO head word
- tx_valid  input  1  TX FIFO not empty
- tx_ready  output  1  pop strobe to TX FIFO
- out_req  input  1  OUT request; held high until out_done
- out_count  input  6  bits to shift out; 0 encodes 32
- out_done  output  1  1-cycle pulse: OUT completed
- pull_req  input  1  explicit PULL; held high until pull_done
- pull_block  input  1  1 = blocking PULL
- x_in  input  32  X scratch value, loaded by non-blocking PULL on empty FIFO
- pull_done  output  1  1-cycle pulse: PULL completed
- stall  output  1  high while a request waits on an empty FIFO
- write_data  output  32  bits for pin block, right-aligned
- write_enable  output  1  1-cycle strobe qualifying write_data
- osr_count  output  6  current shift count (0 = full, 32 = empty)

Behaviour:
- Reset (reset_n low at clock edge):
  - OSR = 0, osr_count = 32, state = IDLE.
  - tx_ready, out_done, pull_done, write_enable, stall all 0; write_data = 0.
- Reset mid-stall aborts the request with no done pulse and no FIFO pop.
- Let n = out_count (0 → 32) and th = cfg_pullThresh (0 → 32).
- FSM states: IDLE, OUT_STALL, PULL_STALL.
- IDLE, out_req, and refill needed (cfg_autoPull && osr_count >= th):
  - tx_valid = 1: assert tx_ready, load OSR = tx_data, set count = 0. Stay IDLE; the OUT executes next cycle.
  - tx_valid = 0: go to OUT_STALL with stall = 1.
- IDLE, out_req, no refill needed: the OUT executes this cycle.
  - Shift right: write_data = OSR & ((1<<n)-1), OSR >>= n.
  - Shift left: write_data = OSR >> (32-n), OSR <<= n.
  - Vacated bits fill with 0.
  - count = min(count+n, 32).
  - write_enable and out_done pulse on the next cycle (latency 1 from acceptance).
  - n = 32 shifts out the whole OSR, and the OSR becomes 0.
- OUT_STALL: on the first cycle with tx_valid, load and pop. The OUT executes the following cycle; return to IDLE.
- IDLE, pull_req:
  - tx_valid = 1: load OSR, count = 0, pop, pull_done next cycle.
  - tx_valid = 0 and pull_block = 0: OSR = x_in, count = 0, pull_done next cycle, no pop.
  - tx_valid = 0 and pull_block = 1: go to PULL_STALL with stall = 1; complete on the first tx_valid.
- out_req and pull_req together: PULL wins; the OUT is serviced after pull_done.
- Background autopull: in IDLE with no request, cfg_autoPull, count >= th and tx_valid, pop and load (count = 0).
- tx_ready is never asserted without tx_valid. At most one pop per cycle.
- Config changes apply only in IDLE. Changing config while stalled is undefined.
- No counter wrap: count saturates at 32. Repeated OUT on an empty OSR without autopull yields zeros.

Optional Feature:
- Macro: PIO_OSR_STALL_STATS_EN.
- When defined:
  - Adds output stall_cycles (16 bits) and input stats_clear (1 bit).
  - stall_cycles increments each cycle stall = 1 and saturates at 0xFFFF.
  - stats_clear or reset zeroes it; clear wins over increment.
- When undefined: the ports are absent, and there is no counter logic.

Decomposition:
- pio_pkg holds:
  - DATA_W and CNT_W constants.
  - osr_state_t enum (IDLE, OUT_STALL, PULL_STALL).
  - A function decoding the 0 → 32 count encoding.
- Sub-module pio_shift_extract: purely combinational. It takes OSR, n and direction, and returns the extracted bits and the shifted OSR. Verify it standalone.

Test Plan:
- Reset, then PULL with tx_data = 0xDEADBEEF → tx_ready pulses once, pull_done, osr_count = 0.
- Shift right, then OUT n = 8 four times → write_data 0xEF, 0xBE, 0xAD, 0xDE; osr_count 8, 16, 24, 32.
- Shift left, OSR = 0x80000001, OUT n = 1 → write_data = 1, OSR = 0x00000002; then OUT n = 0 (32 bits) → write_data = 0x00000002, count = 32.
- Autopull th = 16, FIFO empty, out_req n = 16 at count 16 → stall high for 5 cycles; tx_valid rises → one pop, then write_enable with the low 16 bits of the new word.
- Non-blocking PULL, FIFO empty, x_in = 0x12345678 → OSR = 0x12345678, no tx_ready, pull_done; blocking PULL stalls until tx_valid.
- Assert reset_n low during PULL_STALL → all outputs return to reset values, then no pop when tx_valid arrives.
